// File: rtl/aes_stim_pkg.sv
// ---------------------------------------------------------------------------
// aes_stim_pkg
// Shared definitions for the AES stimulus sequencer slice:
//   - seq_state_e : FSM encoding (IDLE, SEED, RUN, DRAIN, DONE)
//   - TAP_*       : feedback tap positions shared by the LFSRs and the MISR
//   - DEFAULT_*   : default plaintext/key seeds and the aes_128 latency
//   - tap_parity  : XOR of the four tap bits of a 128-bit word
// ---------------------------------------------------------------------------
package aes_stim_pkg;

    localparam int LFSR_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int TAP_A = 127;
    localparam int TAP_B = 125;
    localparam int TAP_C = 100;
    localparam int TAP_D = 98;

    localparam logic [LFSR_W-1:0] DEFAULT_STATE_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [LFSR_W-1:0] DEFAULT_KEY_SEED   = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED;
    localparam int                AES_LATENCY        = 21;

    // The LFSRs and the MISR use the same four taps; the LFSRs invert the
    // parity (XNOR feedback) so an all-zero word can never lock them up,
    // while the MISR uses the plain parity.
    function automatic logic tap_parity(input logic [LFSR_W-1:0] v);
        return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
    endfunction

endpackage

// File: rtl/aes_stim_lfsr.sv
// ---------------------------------------------------------------------------
// aes_stim_lfsr
// Seeded 128-bit Fibonacci LFSR with XNOR feedback, used for both the
// plaintext and the key stream.
// Ports:
//   clk   in   1         clock
//   rst   in   1         synchronous active-high reset, loads SEED
//   en    in   1         advance one step this cycle
//   load  in   1         reload SEED this cycle (wins over en)
//   q     out  NUM_BITS  current LFSR word
// ---------------------------------------------------------------------------
module aes_stim_lfsr
    import aes_stim_pkg::*;
#(
    parameter int                  NUM_BITS = 128,
    parameter logic [NUM_BITS-1:0] SEED     = DEFAULT_STATE_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    output logic [NUM_BITS-1:0] q
);

    logic [NUM_BITS-1:0] q_next;

    // One LFSR step: shift toward the MSB and insert the inverted tap
    // parity at bit 0.
    always_comb begin
        q_next = {q[NUM_BITS-2:0], ~tap_parity(q)};
    end

    // Reset and an explicit reload both return the register to its seed so
    // every run starts from the same vector; otherwise it only moves when
    // the sequencer asks for a fresh vector, which lets it hold the last
    // word while the pipeline drains.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= SEED;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/aes_stim_sequencer.sv
// ---------------------------------------------------------------------------
// aes_stim_sequencer
// Drives N back-to-back plaintext/key vectors into aes_128, tracks the
// fixed AES latency to flag each returned ciphertext with its index, and
// folds every ciphertext into a MISR signature.
// Ports:
//   clk           in   1         clock shared with aes_128
//   rst           in   1         synchronous active-high reset
//   start         in   1         begin a run (only looked at in IDLE)
//   num_tests     in   CNT_W     vectors to issue, latched on accepted start
//   state_o       out  NUM_BITS  plaintext to aes_128
//   key_o         out  NUM_BITS  key to aes_128
//   vec_valid     out  1         state_o/key_o carry a new vector
//   aes_out       in   NUM_BITS  ciphertext from aes_128
//   result_valid  out  1         aes_out belongs to vector result_idx
//   result_idx    out  CNT_W     0-based index of the current result
//   busy          out  1         high in SEED/RUN/DRAIN
//   done          out  1         run complete, sticky until next start/rst
//   signature     out  NUM_BITS  MISR over all results of the run
// ---------------------------------------------------------------------------
module aes_stim_sequencer
    import aes_stim_pkg::*;
#(
    parameter int                  NUM_BITS   = 128,
    parameter int                  LATENCY    = AES_LATENCY,
    parameter logic [NUM_BITS-1:0] STATE_SEED = DEFAULT_STATE_SEED,
    parameter logic [NUM_BITS-1:0] KEY_SEED   = DEFAULT_KEY_SEED,
    parameter int                  CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_tests,
    output logic [NUM_BITS-1:0] state_o,
    output logic [NUM_BITS-1:0] key_o,
    output logic                vec_valid,
    input  logic [NUM_BITS-1:0] aes_out,
    output logic                result_valid,
    output logic [CNT_W-1:0]    result_idx,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] signature
);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    vec_cnt_q;
    logic [CNT_W-1:0]    result_idx_q;
    logic [LATENCY-1:0]  valid_pipe_q;
    logic                done_q;
    logic [NUM_BITS-1:0] sig_q;
    logic [NUM_BITS-1:0] sig_next;
    logic                lfsr_load;
    logic                lfsr_en;
    logic                accept_start;
    logic                last_vec;
    logic                last_result;

    // Plaintext and key streams: identical LFSRs that differ only in seed.
    aes_stim_lfsr #(
        .NUM_BITS (NUM_BITS),
        .SEED     (STATE_SEED)
    ) u_state_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .load (lfsr_load),
        .q    (state_o)
    );

    aes_stim_lfsr #(
        .NUM_BITS (NUM_BITS),
        .SEED     (KEY_SEED)
    ) u_key_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .load (lfsr_load),
        .q    (key_o)
    );

    // A result is simply a vec_valid that has travelled LATENCY stages, so
    // result_valid needs no knowledge of the FSM. The N-th vector and the
    // N-th result are recognised by comparing their counters with the
    // latched count.
    assign result_valid = valid_pipe_q[LATENCY-1];
    assign accept_start = (state_q == ST_IDLE) && start;
    assign last_vec     = (vec_cnt_q == (num_q - CNT_W'(1)));
    assign last_result  = result_valid && (result_idx_q == (num_q - CNT_W'(1)));

    assign vec_valid    = (state_q == ST_RUN);
    assign busy         = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = done_q;
    assign result_idx   = result_idx_q;
    assign signature    = sig_q;

    // Signature step: shift the MISR with its tap parity fed back into
    // bit 0, then fold in the current ciphertext.
    always_comb begin
        sig_next = {sig_q[NUM_BITS-2:0], tap_parity(sig_q)} ^ aes_out;
    end

    // Next-state logic. SEED reloads both LFSRs so the first RUN cycle
    // presents the seeds themselves. During RUN the LFSRs advance after
    // every vector except the last one, so in DRAIN they still show the
    // final vector. start is only honoured in IDLE; a zero count goes
    // straight to DONE without touching the datapath.
    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_tests == '0) ? ST_DONE : ST_SEED;
                end
            end
            ST_SEED: begin
                lfsr_load = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (last_vec) begin
                    state_d = ST_DRAIN;
                end else begin
                    lfsr_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (last_result) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, valid pipe, counters, done flag and MISR. Reset
    // empties the valid pipe so nothing launched before it can ever be
    // flagged as a result. An accepted start clears the previous run's
    // signature, index and done flag; done is set on the way into DONE,
    // which is the cycle after the final result and the cycle busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            num_q        <= '0;
            vec_cnt_q    <= '0;
            result_idx_q <= '0;
            valid_pipe_q <= '0;
            done_q       <= 1'b0;
            sig_q        <= '0;
        end else begin
            state_q      <= state_d;
            valid_pipe_q <= {valid_pipe_q[LATENCY-2:0], vec_valid};

            if (state_d == ST_DONE) begin
                done_q <= 1'b1;
            end else if (accept_start) begin
                done_q <= 1'b0;
            end

            if (accept_start) begin
                num_q        <= num_tests;
                vec_cnt_q    <= '0;
                result_idx_q <= '0;
                sig_q        <= '0;
            end else begin
                if (state_q == ST_RUN) begin
                    vec_cnt_q <= vec_cnt_q + CNT_W'(1);
                end
                if (result_valid) begin
                    result_idx_q <= result_idx_q + CNT_W'(1);
                    sig_q        <= sig_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_stim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_stim_sequencer
// Self-checking bench for aes_stim_sequencer. A stand-in for aes_128 (a
// keyed mixing function behind a 21-stage delay line) closes the loop.
// Expected vectors, result timing and signatures come from a reference
// model built directly from the LFSR/MISR rules and run-level timing.
// ---------------------------------------------------------------------------
module tb_aes_stim_sequencer;

    localparam int LAT = 21;
    localparam logic [127:0] S_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] K_SEED = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  num_tests;
    logic [127:0] state_o;
    logic [127:0] key_o;
    logic         vec_valid;
    logic [127:0] aes_out;
    logic         result_valid;
    logic [31:0]  result_idx;
    logic         busy;
    logic         done;
    logic [127:0] signature;

    logic [127:0] salt;
    logic [127:0] aes_pipe [LAT];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           num;
        bit           poke;
        logic [127:0] v0_state;
        logic [127:0] v0_key;
        logic [127:0] v1_state;
        logic [127:0] v1_key;
        int           done_cyc;
    } vec_rec_t;

    vec_rec_t     tab [6];
    logic [127:0] tab_sig [6];
    logic [127:0] sig_tmp;
    logic [127:0] sig_rerun;

    aes_stim_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_tests    (num_tests),
        .state_o      (state_o),
        .key_o        (key_o),
        .vec_valid    (vec_valid),
        .aes_out      (aes_out),
        .result_valid (result_valid),
        .result_idx   (result_idx),
        .busy         (busy),
        .done         (done),
        .signature    (signature)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lfsr_step(input logic [127:0] v);
        return {v[126:0], ~(v[127] ^ v[125] ^ v[100] ^ v[98])};
    endfunction

    function automatic logic [127:0] misr_step(input logic [127:0] s, input logic [127:0] d);
        return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]} ^ d;
    endfunction

    function automatic logic [127:0] fake_aes(input logic [127:0] s, input logic [127:0] k,
                                              input logic [127:0] x);
        return s ^ {k[63:0], k[127:64]} ^ x;
    endfunction

    // Stand-in for aes_128: fixed 21-cycle latency, output depends on the
    // plaintext/key presented 21 cycles earlier.
    always @(posedge clk) begin
        aes_pipe[0] <= fake_aes(state_o, key_o, salt);
        for (int i = 1; i < LAT; i++) aes_pipe[i] <= aes_pipe[i-1];
    end
    assign aes_out = aes_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state_o"},      state_o,      S_SEED);
        checkOutput({tag, "_key_o"},        key_o,        K_SEED);
        checkOutput({tag, "_vec_valid"},    vec_valid,    0);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_busy"},         busy,         0);
        checkOutput({tag, "_done"},         done,         0);
        checkOutput({tag, "_result_idx"},   result_idx,   0);
        checkOutput({tag, "_signature"},    signature,    0);
    endtask

    // Presents start for one cycle; returns at the negedge of the first
    // cycle after the accepting edge.
    task automatic applyStimulus(input int n);
        @(negedge clk);
        start     = 1'b1;
        num_tests = n;
        @(negedge clk);
        start     = 1'b0;
        num_tests = $urandom;
    endtask

    // One complete run. rst_after > 0 asserts rst right after that many
    // results have been seen and checks the aftermath instead of done.
    task automatic runTest(input vec_rec_t r, input int rst_after, output logic [127:0] sig_seen);
        logic [127:0] vs [$];
        logic [127:0] vk [$];
        int           issue [$];
        logic [127:0] s, k, msig;
        int           vi, ri, last_res_cyc, bound, stray;
        bit           finished;

        s = S_SEED;
        k = K_SEED;
        msig = '0;
        for (int i = 0; i < r.num; i++) begin
            vs.push_back(s);
            vk.push_back(k);
            msig = misr_step(msig, fake_aes(s, k, salt));
            s = lfsr_step(s);
            k = lfsr_step(k);
        end

        vi = 0;
        ri = 0;
        last_res_cyc = 0;
        finished = 1'b0;
        sig_seen = '0;
        bound = r.num + LAT + 10;

        applyStimulus(r.num);
        for (int cyc = 1; cyc <= bound && !finished; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start = 1'b0;
            if (vec_valid) begin
                if (vi < r.num) begin
                    checkOutput("vec_state", state_o, vs[vi]);
                    checkOutput("vec_key", key_o, vk[vi]);
                    if (vi == 0) begin
                        checkOutput("first_state", state_o, r.v0_state);
                        checkOutput("first_key", key_o, r.v0_key);
                    end
                    if (vi == 1) begin
                        checkOutput("second_state", state_o, r.v1_state);
                        checkOutput("second_key", key_o, r.v1_key);
                    end
                    issue.push_back(cyc);
                end else begin
                    checkOutput("extra_vec_valid", 1, 0);
                end
                vi++;
            end
            if (result_valid) begin
                if (ri < issue.size()) begin
                    checkOutput("result_idx", result_idx, ri);
                    checkOutput("result_latency", cyc, issue[ri] + LAT);
                end else begin
                    checkOutput("spurious_result", 1, 0);
                end
                ri++;
                last_res_cyc = cyc;
                if (rst_after > 0 && ri == rst_after) begin
                    rst = 1'b1;
                    finished = 1'b1;
                end
            end
            if (done && !finished) begin
                checkOutput("vec_count", vi, r.num);
                checkOutput("result_count", ri, r.num);
                checkOutput("done_cycle", cyc, r.done_cyc);
                if (r.num > 0) checkOutput("done_after_last_result", cyc, last_res_cyc + 1);
                checkOutput("busy_at_done", busy, 0);
                checkOutput("signature", signature, msig);
                sig_seen = signature;
                finished = 1'b1;
            end
            if (r.poke && !finished && busy && (vi == 1 || (vi >= r.num && !vec_valid))) begin
                if (vi == 1 || $urandom_range(0, 1) == 1) begin
                    start     = 1'b1;
                    num_tests = $urandom_range(1, 50);
                end
            end
        end
        start = 1'b0;

        if (!finished) begin
            checkOutput("timeout", 0, 1);
        end else if (rst_after > 0) begin
            @(negedge clk);
            checkReset("mid_run_reset");
            rst = 1'b0;
            stray = 0;
            for (int i = 0; i < LAT + 5; i++) begin
                @(negedge clk);
                if (result_valid || vec_valid || busy) stray++;
            end
            checkOutput("activity_after_reset", stray, 0);
        end else begin
            if (r.poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput("done_sticky", done, 1);
            checkOutput("busy_after_done", busy, 0);
            checkOutput("signature_held", signature, msig);
            @(negedge clk);
            checkOutput("idle_not_restarted", busy, 0);
        end
    endtask

    initial begin
        tab[0] = '{1,  1'b0, S_SEED, K_SEED, 128'h0, 128'h0, 24};
        tab[1] = '{4,  1'b0, S_SEED, K_SEED, {4{32'hBD5B7DDF}}, {4{32'h95FDFDDB}}, 27};
        tab[2] = '{0,  1'b0, S_SEED, K_SEED, 128'h0, 128'h0, 1};
        tab[3] = '{3,  1'b0, S_SEED, K_SEED, {4{32'hBD5B7DDF}}, {4{32'h95FDFDDB}}, 26};
        tab[4] = '{3,  1'b1, S_SEED, K_SEED, {4{32'hBD5B7DDF}}, {4{32'h95FDFDDB}}, 26};
        tab[5] = '{10, 1'b0, S_SEED, K_SEED, {4{32'hBD5B7DDF}}, {4{32'h95FDFDDB}}, 33};

        salt      = '0;
        rst       = 1'b1;
        start     = 1'b1;
        num_tests = 5;
        repeat (3) @(negedge clk);
        checkReset("reset");
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checkReset("post_reset_idle");

        for (int t = 0; t < 6; t++) begin
            $display("[TB] table run %0d: N=%0d poke=%0d", t, tab[t].num, tab[t].poke);
            runTest(tab[t], 0, tab_sig[t]);
        end
        checkOutput("zero_run_signature", tab_sig[2], 0);
        checkOutput("poked_vs_clean_sig", tab_sig[4], tab_sig[3]);

        $display("[TB] N=10 with reset at 5th result, then rerun");
        runTest(tab[5], 5, sig_tmp);
        runTest(tab[5], 0, sig_rerun);
        checkOutput("rerun_signature", sig_rerun, tab_sig[5]);

        for (int j = 0; j < 6; j++) begin
            vec_rec_t rr;
            rr.num      = $urandom_range(1, 40);
            rr.poke     = $urandom_range(0, 1);
            rr.v0_state = S_SEED;
            rr.v0_key   = K_SEED;
            rr.v1_state = {4{32'hBD5B7DDF}};
            rr.v1_key   = {4{32'h95FDFDDB}};
            rr.done_cyc = rr.num + LAT + 2;
            salt = {$urandom, $urandom, $urandom, $urandom};
            $display("[TB] random run %0d: N=%0d poke=%0d", j, rr.num, rr.poke);
            runTest(rr, 0, sig_tmp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
